// File: rtl/lmi_iram_arb.sv
// lmi_iram_arb: shares a single-ported IRAM between the IF and LS ports.
// Define LMI_IRAM_ARB_RR_EN for round-robin instead of LS priority + starve.
module lmi_iram_arb #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       IRAM_BASE,
  input  logic [11:0]       IRAM_TOP,
  input  logic              IF_REQ,
  input  logic [31:0]       IF_ADDR,
  output logic              IF_ACK,
  output logic              IF_RVALID,
  output logic              IF_ERR,
  input  logic              LS_REQ,
  input  logic              LS_WE,
  input  logic [31:0]       LS_ADDR,
  input  logic [3:0]        LS_BE,
  input  logic [31:0]       LS_WDATA,
  output logic              LS_ACK,
  output logic              LS_RVALID,
  output logic              LS_ERR,
  output logic [31:0]       RDATA,
  output logic              RAM_CS,
  output logic              RAM_WE,
  output logic [RAM_AW-1:0] RAM_ADDR,
  output logic [3:0]        RAM_BE,
  output logic [31:0]       RAM_WDATA,
  input  logic [31:0]       RAM_RDATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_e;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              if_err_q, if_err_d;
  logic              ls_err_q, ls_err_d;

`ifdef LMI_IRAM_ARB_RR_EN
  logic              last_q, last_d;
`else
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0]        starve_q, starve_d;
`endif

  logic if_hit, ls_hit;
  logic if_cand, ls_cand, if_win;
  logic acc, rvalid;
  logic unused_addr;

  assign unused_addr = ^{IF_ADDR[1:0], LS_ADDR[1:0]};

  always_comb begin
    if_hit = (IF_ADDR[31:16] == IRAM_BASE) &&
             (IF_ADDR[15:4] <= IRAM_TOP);
    ls_hit = (LS_ADDR[31:16] == IRAM_BASE) &&
             (LS_ADDR[15:4] <= IRAM_TOP);
    if_cand = IF_REQ & if_hit;
    ls_cand = LS_REQ & ls_hit;
`ifdef LMI_IRAM_ARB_RR_EN
    // last_q = 1 means LS was granted last
    if_win = if_cand & (~ls_cand | last_q);
`else
    if_win = if_cand & (~ls_cand | (starve_q == SMAX));
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    if_err_d = 1'b0;
    ls_err_d = 1'b0;
`ifdef LMI_IRAM_ARB_RR_EN
    last_d   = last_q;
`else
    starve_d = starve_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if_err_d = IF_REQ & ~if_hit;
        ls_err_d = LS_REQ & ~ls_hit;
        if (if_cand | ls_cand) begin
          state_d = S_ACCESS;
          owner_d = ~if_win;
          we_d    = ~if_win & LS_WE;
          addr_d  = if_win ? IF_ADDR[RAM_AW+1:2]
                           : LS_ADDR[RAM_AW+1:2];
          be_d    = if_win ? 4'hF : LS_BE;
          wdata_d = if_win ? 32'h0 : LS_WDATA;
`ifdef LMI_IRAM_ARB_RR_EN
          last_d  = ~if_win;
`else
          if (if_win)
            starve_d = 4'd0;
          else if (if_cand && starve_q != SMAX)
            starve_d = starve_q + 4'd1;
`endif
        end
      end
      S_ACCESS: begin
        state_d = we_q ? S_IDLE : S_WAIT;
        cnt_d   = WS;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      if_err_q <= 1'b0;
      ls_err_q <= 1'b0;
`ifdef LMI_IRAM_ARB_RR_EN
      last_q   <= 1'b0;
`else
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      if_err_q <= if_err_d;
      ls_err_q <= ls_err_d;
`ifdef LMI_IRAM_ARB_RR_EN
      last_q   <= last_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  assign acc    = (state_q == S_ACCESS);
  assign rvalid = (state_q == S_WAIT) && (cnt_q == 3'd1);

  assign IF_ACK    = acc & ~owner_q;
  assign LS_ACK    = acc & owner_q;
  assign IF_RVALID = rvalid & ~owner_q;
  assign LS_RVALID = rvalid & owner_q;
  assign IF_ERR    = if_err_q;
  assign LS_ERR    = ls_err_q;
  assign RDATA     = rvalid ? RAM_RDATA : 32'h0;

  // RAM bus is quiet outside the access cycle
  assign RAM_CS    = acc;
  assign RAM_WE    = acc & we_q;
  assign RAM_ADDR  = acc ? addr_q : '0;
  assign RAM_BE    = acc ? be_q : 4'h0;
  assign RAM_WDATA = acc ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lmi_iram_arb.sv
// tb_lmi_iram_arb: vector table, read-data scoreboard and corner sequences.
// Two DUTs: WAIT_STATES=1 (main) and WAIT_STATES=3 (latency checks).
module tb_lmi_iram_arb;

  typedef struct {
    logic        ls;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        hit;
    logic [9:0]  raddr;
  } vec_t;

  typedef struct {
    logic        ls;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base;
  logic [11:0] top;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_be;

  logic        o0_if_ack, o0_if_rvalid, o0_if_err;
  logic        o0_ls_ack, o0_ls_rvalid, o0_ls_err;
  logic [31:0] o0_rdata, o0_ram_wdata, ram_rdata0;
  logic        o0_ram_cs, o0_ram_we;
  logic [9:0]  o0_ram_addr, raddr0;
  logic [3:0]  o0_ram_be;

  logic        o3_if_ack, o3_if_rvalid, o3_if_err;
  logic        o3_ls_ack, o3_ls_rvalid, o3_ls_err;
  logic [31:0] o3_rdata, o3_ram_wdata, ram_rdata3;
  logic        o3_ram_cs, o3_ram_we;
  logic [9:0]  o3_ram_addr, raddr3;
  logic [3:0]  o3_ram_be;

  int   total = 0;
  int   bad = 0;
  sb_t  sb0[$];
  vec_t vt[9];

`ifdef LMI_IRAM_ARB_RR_EN
  bit arb_exp[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
  bit arb_exp[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
  logic [3:0] ws3_exp[10] = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h2,
                              4'h0, 4'h4, 4'h0, 4'h0, 4'h1};

  always #5 clk = ~clk;

  lmi_iram_arb #(.RAM_AW(10), .WAIT_STATES(1), .STARVE_MAX(4)) u0 (
    .CLK(clk), .RST(rst), .IRAM_BASE(base), .IRAM_TOP(top),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(o0_if_ack),
    .IF_RVALID(o0_if_rvalid), .IF_ERR(o0_if_err),
    .LS_REQ(ls_req), .LS_WE(ls_we), .LS_ADDR(ls_addr),
    .LS_BE(ls_be), .LS_WDATA(ls_wdata), .LS_ACK(o0_ls_ack),
    .LS_RVALID(o0_ls_rvalid), .LS_ERR(o0_ls_err), .RDATA(o0_rdata),
    .RAM_CS(o0_ram_cs), .RAM_WE(o0_ram_we), .RAM_ADDR(o0_ram_addr),
    .RAM_BE(o0_ram_be), .RAM_WDATA(o0_ram_wdata),
    .RAM_RDATA(ram_rdata0)
  );

  lmi_iram_arb #(.RAM_AW(10), .WAIT_STATES(3), .STARVE_MAX(4)) u3 (
    .CLK(clk), .RST(rst), .IRAM_BASE(base), .IRAM_TOP(top),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(o3_if_ack),
    .IF_RVALID(o3_if_rvalid), .IF_ERR(o3_if_err),
    .LS_REQ(ls_req), .LS_WE(ls_we), .LS_ADDR(ls_addr),
    .LS_BE(ls_be), .LS_WDATA(ls_wdata), .LS_ACK(o3_ls_ack),
    .LS_RVALID(o3_ls_rvalid), .LS_ERR(o3_ls_err), .RDATA(o3_rdata),
    .RAM_CS(o3_ram_cs), .RAM_WE(o3_ram_we), .RAM_ADDR(o3_ram_addr),
    .RAM_BE(o3_ram_be), .RAM_WDATA(o3_ram_wdata),
    .RAM_RDATA(ram_rdata3)
  );

  // RAM model: read data encodes the word address of the last read
  always @(posedge clk) begin
    if (o0_ram_cs && !o0_ram_we) raddr0 <= o0_ram_addr;
    if (o3_ram_cs && !o3_ram_we) raddr3 <= o3_ram_addr;
  end
  assign ram_rdata0 = {16'hC0DE, 6'd0, raddr0};
  assign ram_rdata3 = {16'hC0DE, 6'd0, raddr3};

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return {16'hC0DE, 6'd0, a[11:2]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic any0();
    return |{o0_if_ack, o0_if_rvalid, o0_if_err, o0_ls_ack,
             o0_ls_rvalid, o0_ls_err, o0_rdata, o0_ram_cs,
             o0_ram_we, o0_ram_addr, o0_ram_be, o0_ram_wdata};
  endfunction

  function automatic logic any3();
    return |{o3_if_ack, o3_if_rvalid, o3_if_err, o3_ls_ack,
             o3_ls_rvalid, o3_ls_err, o3_rdata, o3_ram_cs,
             o3_ram_we, o3_ram_addr, o3_ram_be, o3_ram_wdata};
  endfunction

  // Scoreboard pop on every read-data beat of the main DUT
  always @(negedge clk) begin
    sb_t e;
    if (o0_if_rvalid || o0_ls_rvalid) begin
      if (sb0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb0_unexpected if_rv=%0b ls_rv=%0b exp=none",
                 o0_if_rvalid, o0_ls_rvalid);
      end else begin
        e = sb0.pop_front();
        chk("sb0_rv", {o0_if_rvalid, o0_ls_rvalid}, {~e.ls, e.ls});
        chk("sb0_rdata", o0_rdata, e.data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    if (v.ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr;
      ls_be = v.be; ls_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    if (v.hit && !v.we) sb0.push_back('{v.ls, exp_rd(v.addr)});
    @(negedge clk);
    chk($sformatf("vec%0d_ctl", idx),
        {o0_if_ack, o0_ls_ack, o0_if_err, o0_ls_err, o0_ram_cs},
        v.hit ? {~v.ls, v.ls, 2'b00, 1'b1}
              : {2'b00, ~v.ls, v.ls, 1'b0});
    if (v.hit)
      chk($sformatf("vec%0d_addr", idx), {o0_ram_we, o0_ram_addr},
          {v.we, v.raddr});
    if (v.hit && v.ls)
      chk($sformatf("vec%0d_data", idx), {o0_ram_be, o0_ram_wdata},
          {v.be, v.wdata});
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_after", idx),
        {o0_if_ack, o0_ls_ack, o0_if_err, o0_ls_err, o0_ram_cs}, 5'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int g;
    base = 16'h0040; top = 12'h0FF;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0;
    ls_be = 4'h0; ls_wdata = 32'h0;

    vt[0] = '{1'b0, 1'b0, 32'h0040_0010, 4'h0, 32'h0, 1'b1, 10'h004};
    vt[1] = '{1'b1, 1'b1, 32'h0040_0FFC, 4'b0011, 32'hDEADBEEF,
              1'b1, 10'h3FF};
    vt[2] = '{1'b1, 1'b0, 32'h0040_1000, 4'hF, 32'h0, 1'b0, 10'h000};
    vt[3] = '{1'b1, 1'b0, 32'h0040_0000, 4'hF, 32'h0, 1'b1, 10'h000};
    vt[4] = '{1'b0, 1'b0, 32'h0041_0010, 4'h0, 32'h0, 1'b0, 10'h000};
    vt[5] = '{1'b0, 1'b0, 32'h0040_0FF0, 4'h0, 32'h0, 1'b1, 10'h3FC};
    vt[6] = '{1'b1, 1'b1, 32'h0040_0124, 4'b1000, 32'h12345678,
              1'b1, 10'h049};
    vt[7] = '{1'b0, 1'b0, 32'h003F_FFFC, 4'h0, 32'h0, 1'b0, 10'h000};
    vt[8] = '{1'b1, 1'b0, 32'h0040_0ABC, 4'b0100, 32'h0, 1'b1, 10'h2AF};

    // Reset with a request pending: nothing may leak out
    if_req = 1'b1; if_addr = 32'h0040_0010;
    repeat (3) @(negedge clk);
    chk("rst_outs0", any0(), 1'b0);
    chk("rst_outs3", any3(), 1'b0);
    if_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs0", any0(), 1'b0);

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // Both ports requesting continuously
    do_reset();
    for (int i = 0; i < 10; i++)
      sb0.push_back('{arb_exp[i], arb_exp[i] ? exp_rd(32'h0040_0200)
                                               : exp_rd(32'h0040_0100)});
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0040_0200; ls_be = 4'hF;
    g = 0;
    for (int n = 0; n < 80 && g < 10; n++) begin
      @(negedge clk);
      if (o0_if_ack || o0_ls_ack) begin
        chk($sformatf("grant%0d", g), {o0_if_ack, o0_ls_ack},
            {~arb_exp[g], arb_exp[g]});
        g++;
        if (g == 10) begin
          if_req = 1'b0;
          ls_req = 1'b0;
        end
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    chk("grant_count", g, 10);
    repeat (3) @(negedge clk);
    chk("arb_drain", sb0.size(), 0);

    // Reset in the WAIT cycle of an IF read
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0044;
    @(negedge clk);
    chk("rw_if_ack", o0_if_ack, 1'b1);
    if_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rw_outs0", any0(), 1'b0);
    rst = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0040_0050; ls_be = 4'hF;
    sb0.push_back('{1'b1, exp_rd(32'h0040_0050)});
    @(negedge clk);
    chk("rw_ls_ack", {o0_ls_ack, o0_ram_cs, o0_ram_addr},
        {1'b1, 1'b1, 10'h014});
    ls_req = 1'b0;
    @(negedge clk);
    chk("rw_ls_rvalid", o0_ls_rvalid, 1'b1);
    repeat (2) @(negedge clk);

    // Held miss on IF beside an LS hit
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_1000;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0040_0060; ls_be = 4'hF;
    sb0.push_back('{1'b1, exp_rd(32'h0040_0060)});
    @(negedge clk);
    chk("dm_k1", {o0_if_err, o0_ls_ack, o0_ram_cs, o0_if_ack}, 4'b1110);
    ls_req = 1'b0;
    @(negedge clk);
    chk("dm_k2", o0_if_err, 1'b0);
    @(negedge clk);
    chk("dm_k3", o0_if_err, 1'b0);
    @(negedge clk);
    chk("dm_k4", {o0_if_err, o0_if_ack, o0_ram_cs}, 3'b100);
    @(negedge clk);
    chk("dm_k5", o0_if_err, 1'b1);
    if_req = 1'b0;
    @(negedge clk);
    chk("dm_k6", o0_if_err, 1'b0);
    repeat (2) @(negedge clk);

    // WAIT_STATES=3 latency and a request arriving mid-WAIT
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0020;
    sb0.push_back('{1'b0, exp_rd(32'h0040_0020)});
    sb0.push_back('{1'b1, exp_rd(32'h0040_0030)});
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("ws3_k%0d", k),
          {o3_if_ack, o3_ls_ack, o3_if_rvalid, o3_ls_rvalid}, ws3_exp[k]);
      if (k == 1) if_req = 1'b0;
      if (k == 2) begin
        ls_req = 1'b1; ls_we = 1'b0;
        ls_addr = 32'h0040_0030; ls_be = 4'hF;
      end
      if (k == 4) chk("ws3_if_rdata", o3_rdata, exp_rd(32'h0040_0020));
      if (k == 6) ls_req = 1'b0;
      if (k == 9) chk("ws3_ls_rdata", o3_rdata, exp_rd(32'h0040_0030));
    end

    repeat (4) @(negedge clk);
    chk("sb0_drain", sb0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
